obi_soc_interconnect: RTL

Parametrised OBI interconnect that replaces the fixed instruction/data arbiter and hard-coded chip/block-select decode in the SoC top. It serves NUM_MASTERS OBI masters (core instruction port, core data port, future DMA) and routes them to NUM_SLAVES OBI slaves (IRAM, DRAM, OBI-WB bridge, peripherals) using a parameter-defined base/mask address map. Arbitration is round-robin with one transaction in flight. Unmapped accesses get an error response, and accesses to slaves that hang are terminated by a timeout.

---
 rtl/obi_ic_pkg.sv | 27 ++
 rtl/obi_soc_interconnect_rr_arbiter.sv | 45 ++++
 rtl/obi_soc_interconnect.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/obi_ic_pkg.sv
// Shared types and default address map for the OBI SoC interconnect.
// No logic; constants only.
// Slave order in the packed maps is IRAM(0), DRAM(1), WB(2), UART(3).
package obi_ic_pkg;

  typedef enum logic [1:0] {
    IC_IDLE = 2'd0,
    IC_REQ  = 2'd1,
    IC_WAIT = 2'd2,
    IC_ERR  = 2'd3
  } e_ic_state;

  localparam logic [31:0] IRAM_BASE = 32'h0000_0000;
  localparam logic [31:0] IRAM_MASK = 32'hFFF8_0000;
  localparam logic [31:0] DRAM_BASE = 32'h0008_0000;
  localparam logic [31:0] DRAM_MASK = 32'hFFF8_0000;
  localparam logic [31:0] WB_BASE   = 32'h0010_0000;
  localparam logic [31:0] WB_MASK   = 32'hFFF8_0000;
  localparam logic [31:0] UART_BASE = 32'h0040_0000;
  localparam logic [31:0] UART_MASK = 32'hFFC0_0000;

  localparam logic [127:0] SLAVE_BASE_DEFAULT = {UART_BASE, WB_BASE, DRAM_BASE, IRAM_BASE};
  localparam logic [127:0] SLAVE_MASK_DEFAULT = {UART_MASK, WB_MASK, DRAM_MASK, IRAM_MASK};

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/obi_soc_interconnect_rr_arbiter.sv
// Round-robin arbiter: one-hot grant and index, search starts at the pointer.
// Latency: combinational grant; pointer moves on the clock after update_en.
// Backpressure: none; the pointer only advances when update_en commits a winner.
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [N-1:0]  req,
  input  logic          update_en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] winner
);

  logic [IW-1:0] ptr_q;
  logic          found;
  int unsigned   cand;

  // First requester found walking upwards from the pointer, wrapping at N.
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = (32'(ptr_q) + i) % N;
      if (!found && req[IW'(cand)]) begin
        found             = 1'b1;
        grant[IW'(cand)]  = 1'b1;
        winner            = IW'(cand);
      end
    end
  end

  // Pointer lands one past the committed winner so it has lowest priority next time.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (update_en && found) begin
      ptr_q <= (winner == IW'(N - 1)) ? '0 : winner + IW'(1);
    end
  end

endmodule

// File: rtl/obi_soc_interconnect.sv
// OBI N-master to M-slave interconnect, round-robin, single transaction in flight.
// Latency: zero-wait slave gives grant 2 cycles and rvalid 3 cycles after request.
// Backpressure: masters stall until granted; hung slaves are cut off by the timeout.
module obi_soc_interconnect
  import obi_ic_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = SLAVE_BASE_DEFAULT,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = SLAVE_MASK_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(ERR_RDATA_DEFAULT)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_MASTERS-1:0]            m_req_i,
  output logic [NUM_MASTERS-1:0]            m_gnt_o,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_be_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
  output logic [NUM_MASTERS-1:0]            m_rvalid_o,
  output logic [DATA_WIDTH-1:0]             m_rdata_o,
  output logic                              m_err_o,
  output logic [NUM_SLAVES-1:0]             s_req_o,
  input  logic [NUM_SLAVES-1:0]             s_gnt_i,
  output logic [ADDR_WIDTH-1:0]             s_addr_o,
  output logic                              s_we_o,
  output logic [DATA_WIDTH/8-1:0]           s_be_o,
  output logic [DATA_WIDTH-1:0]             s_wdata_o,
  input  logic [NUM_SLAVES-1:0]             s_rvalid_i,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0]  s_rdata_i,
  output logic [15:0]                       err_count_o
);

  localparam int unsigned BW  = DATA_WIDTH / 8;
  localparam int unsigned MIW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned SIW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned TW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  e_ic_state               state_q, state_d;
  logic [NUM_MASTERS-1:0]  win_oh_q;
  logic [SIW-1:0]          sel_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    we_q;
  logic [BW-1:0]           be_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    pend_gnt_q;   // decode miss still owes the master its grant
  logic                    s_req_q;
  logic [TW-1:0]           cnt_q;
  logic [15:0]             err_cnt_q, err_cnt_d;

  logic [NUM_MASTERS-1:0]  arb_gnt;
  logic [MIW-1:0]          arb_win;
  logic                    arb_upd;
  logic [ADDR_WIDTH-1:0]   win_addr;
  logic [SIW-1:0]          dec_idx;
  logic                    dec_hit;
  logic                    accept, rsp, tmo;
  logic [NUM_SLAVES-1:0]   sel_oh;

  assign arb_upd = (state_q == IC_IDLE) && (|m_req_i);

  rr_arbiter #(.N(NUM_MASTERS)) u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req       (m_req_i),
    .update_en (arb_upd),
    .grant     (arb_gnt),
    .winner    (arb_win)
  );

  assign win_addr = m_addr_i[arb_win*ADDR_WIDTH +: ADDR_WIDTH];

  // Address decode; scanning downwards lets the lowest matching slave win.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int s = NUM_SLAVES - 1; s >= 0; s--) begin
      if ((win_addr & SLAVE_MASK[s*ADDR_WIDTH +: ADDR_WIDTH]) ==
          SLAVE_BASE[s*ADDR_WIDTH +: ADDR_WIDTH]) begin
        dec_hit = 1'b1;
        dec_idx = SIW'(s);
      end
    end
  end

  // Handshake qualifiers; rvalid is only looked at in WAIT, and only from the latched slave.
  assign sel_oh = NUM_SLAVES'(1) << sel_q;
  assign accept = (state_q == IC_REQ) && s_req_q && s_gnt_i[sel_q];
  assign rsp    = (state_q == IC_WAIT) && s_rvalid_i[sel_q];
  assign tmo    = (TIMEOUT_CYCLES != 0) && (cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // FSM next state; grant beats timeout in REQ, rvalid beats timeout in WAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IC_IDLE: if (|m_req_i) state_d = dec_hit ? IC_REQ : IC_ERR;
      IC_REQ:  if (accept) state_d = IC_WAIT; else if (tmo) state_d = IC_ERR;
      IC_WAIT: if (rsp) state_d = IC_IDLE; else if (tmo) state_d = IC_ERR;
      IC_ERR:  if (!pend_gnt_q) state_d = IC_IDLE;
      default: state_d = IC_IDLE;
    endcase
  end

  // Saturating error counter, bumped on the error response cycle.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (state_q == IC_ERR && !pend_gnt_q && err_cnt_q != 16'hFFFF) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // State, latched transaction, slave request and timeout counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IC_IDLE;
      win_oh_q   <= '0;
      sel_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      pend_gnt_q <= 1'b0;
      s_req_q    <= 1'b0;
      cnt_q      <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      err_cnt_q <= err_cnt_d;
      s_req_q   <= (state_q == IC_REQ) && !accept && !tmo;
      if (arb_upd) begin
        win_oh_q   <= arb_gnt;
        sel_q      <= dec_idx;
        addr_q     <= win_addr;
        we_q       <= m_we_i[arb_win];
        be_q       <= m_be_i[arb_win*BW +: BW];
        wdata_q    <= m_wdata_i[arb_win*DATA_WIDTH +: DATA_WIDTH];
        pend_gnt_q <= !dec_hit;
      end else if (state_q == IC_ERR) begin
        pend_gnt_q <= 1'b0;
      end
      if (state_q != IC_REQ && state_d == IC_REQ) begin
        cnt_q <= '0;
      end else if (state_q == IC_REQ || state_q == IC_WAIT) begin
        cnt_q <= cnt_q + TW'(1);
      end
    end
  end

  // Master-side pulses and the shared response data.
  always_comb begin
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    m_err_o    = 1'b0;
    m_rdata_o  = '0;
    case (state_q)
      IC_REQ: if (accept || tmo) m_gnt_o = win_oh_q;
      IC_WAIT: begin
        if (rsp) begin
          m_rvalid_o = win_oh_q;
          m_rdata_o  = s_rdata_i[sel_q*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      IC_ERR: begin
        if (pend_gnt_q) begin
          m_gnt_o = win_oh_q;
        end else begin
          m_rvalid_o = win_oh_q;
          m_err_o    = 1'b1;
          m_rdata_o  = ERR_RDATA;
        end
      end
      default: ;
    endcase
  end

  assign s_req_o     = s_req_q ? sel_oh : '0;
  assign s_addr_o    = addr_q;
  assign s_we_o      = we_q;
  assign s_be_o      = be_q;
  assign s_wdata_o   = wdata_q;
  assign err_count_o = err_cnt_q;

endmodule
